// File: rtl/pad_input_debounce.sv
// Pad receive conditioner: synchronizer, stability-count glitch filter, optional edge strobes.
// Define PAD_DEBOUNCE_EDGE_EN to build the rise_o/fall_o strobe flops; otherwise they read as 0.
module pad_input_debounce #(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_WIDTH   = 8,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pad_i,
    input  logic                 enable_i,
    input  logic [CNT_WIDTH-1:0] threshold_i,
    output logic                 data_o,
    output logic                 rise_o,
    output logic                 fall_o
);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic [CNT_WIDTH-1:0]   cnt_eff;
    logic                   data_q;
    logic                   mismatch;
    logic                   accept_d;

    // The chain free-runs so the filter always sees a fresh sample when re-enabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    assign sync     = sync_q[SYNC_STAGES-1];
    assign mismatch = (sync != data_q);

    // The count is only meaningful while a change is pending; in STABLE it is zero anyway.
    assign cnt_eff  = (state_q == ST_PENDING) ? cnt_q : '0;
    assign accept_d = enable_i && mismatch && (cnt_eff >= threshold_i);
    assign cnt_d    = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            data_q  <= RESET_VAL;
        end else if (!enable_i) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
        end else if (!mismatch) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
        end else if (accept_d) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            data_q  <= sync;
        end else begin
            state_q <= ST_PENDING;
            cnt_q   <= cnt_d;
        end
    end

    assign data_o = data_q;

`ifdef PAD_DEBOUNCE_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Strobes load on the same edge as data_q, so they line up with the new level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= accept_d && sync;
            fall_q <= accept_d && !sync;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: tb/tb_pad_input_debounce.sv
// Scoreboard bench for pad_input_debounce: stimulus queues expected data_o changes,
// a monitor checks every cycle for the queued change or for a held, strobe-free output.
module tb_pad_input_debounce;

    localparam int   SYNC_STAGES = 2;
    localparam int   CNT_WIDTH   = 8;
    localparam logic RESET_VAL   = 1'b0;
`ifdef PAD_DEBOUNCE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 pad = 1'b1;
    logic                 en = 1'b1;
    logic [CNT_WIDTH-1:0] th = 8'd3;
    logic                 data;
    logic                 rise;
    logic                 fall;

    pad_input_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_WIDTH  (CNT_WIDTH),
        .RESET_VAL  (RESET_VAL)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pad_i      (pad),
        .enable_i   (en),
        .threshold_i(th),
        .data_o     (data),
        .rise_o     (rise),
        .fall_o     (fall)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; stable at every negedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic val;
    } ev_t;

    ev_t sb_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  last_exp = 0;
    bit  done = 1'b0;

    task automatic expect_change(input int at, input logic v);
        ev_t e;
        e.cyc = at;
        e.val = v;
        sb_q.push_back(e);
        if (at > last_exp) last_exp = at;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        while (cyc <= last_exp) @(negedge clk);
        @(negedge clk);
    endtask

    // Monitor: owns all comparisons and the summary.
    initial begin : monitor
        logic exp_level;
        logic exp_r;
        logic exp_f;
        ev_t  e;
        exp_level = RESET_VAL;
        while (!done) begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                exp_level = RESET_VAL;
                vectors++;
                if (data !== RESET_VAL || rise !== 1'b0 || fall !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset cyc=%0d got data=%b rise=%b fall=%b want data=%b rise=0 fall=0",
                             cyc, data, rise, fall, RESET_VAL);
                end
            end else if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                e = sb_q.pop_front();
                exp_r = EDGE && e.val;
                exp_f = EDGE && !e.val;
                vectors++;
                $display("event cyc=%0d data=%b rise=%b fall=%b", cyc, data, rise, fall);
                if (data !== e.val || rise !== exp_r || fall !== exp_f) begin
                    miscompares++;
                    $display("FAIL change cyc=%0d got data=%b rise=%b fall=%b want data=%b rise=%b fall=%b",
                             cyc, data, rise, fall, e.val, exp_r, exp_f);
                end
                exp_level = e.val;
            end else begin
                vectors++;
                if (data !== exp_level || rise !== 1'b0 || fall !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hold cyc=%0d got data=%b rise=%b fall=%b want data=%b rise=0 fall=0",
                             cyc, data, rise, fall, exp_level);
                end
            end
        end
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending events want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

    initial begin : stimulus
        // Reset held with pad high; release, then 2 sync + 3 count + 1 accept = 6 edges.
        step(3);
        rst_n = 1'b1;
        expect_change(cyc + 6, 1'b1);
        drain();

        // Bring data low with threshold 4: 2 + 4 + 1 = 7.
        th  = 8'd4;
        pad = 1'b0;
        expect_change(cyc + 7, 1'b0);
        drain();
        step(5);

        // 4-cycle pulse is rejected, 5-cycle level is accepted.
        pad = 1'b1;
        step(4);
        pad = 1'b0;
        step(12);
        pad = 1'b1;
        expect_change(cyc + 7, 1'b1);
        drain();

        // Pass-through: fixed 3-cycle delay, one strobe per toggle.
        th = 8'd0;
        repeat (6) begin
            pad = ~pad;
            expect_change(cyc + 3, pad);
            step(3);
        end
        drain();

        // Enable gating: two counts accumulated, then cleared while disabled.
        th = 8'd5;
        step(2);
        pad = 1'b0;
        step(4);
        en = 1'b0;
        step(10);
        en = 1'b1;
        expect_change(cyc + 6, 1'b0);
        drain();

        // Threshold lowered after 50 mismatching cycles: accept on the next edge.
        th = 8'd200;
        step(2);
        pad = 1'b1;
        step(52);
        th = 8'd10;
        expect_change(cyc + 1, 1'b1);
        drain();

        // Reset during a pending fall: no strobe, data returns to reset value.
        th = 8'd20;
        step(2);
        pad = 1'b0;
        step(10);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(30);

        // Maximum threshold: 2 + 255 + 1 = 258 edges.
        th  = 8'd255;
        pad = 1'b1;
        expect_change(cyc + 258, 1'b1);
        drain();
        step(5);

        done = 1'b1;
    end

endmodule

// File: doc/pad_input_debounce.md
# pad_input_debounce

Input conditioning stage directly downstream of a functional pad cell: takes the raw asynchronous pad receive signal, synchronizes it into the core clock domain, suppresses glitches shorter than a programmable number of cycles, and emits a clean level plus optional single-cycle edge strobes. It sits between the pad ring and any core consumer of a pad input (GPIO, interrupt logic, wake-up logic).

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops, legal range 2..4.
- `CNT_WIDTH`, default 8: width of the stability counter and `threshold_i`.
- `RESET_VAL`, default 1'b0: reset value of the synchronizer chain and `data_o`.

Ports:
- `clk_i`  input  1  core clock.
- `rst_ni`  input  1  asynchronous active-low reset.
- `pad_i`  input  1  raw pad receive value, asynchronous to `clk_i`.
- `enable_i`  input  1  filter enable; when low, `data_o` holds.
- `threshold_i`  input  CNT_WIDTH  number of extra stable cycles required before a change is accepted.
- `data_o`  output  1  debounced level.
- `rise_o`  output  1  one-cycle strobe on an accepted 0->1 change.
- `fall_o`  output  1  one-cycle strobe on an accepted 1->0 change.

## Operation
- Synchronizer: `SYNC_STAGES` flops in series. Every flop resets to `RESET_VAL`. The last stage is `sync`. The chain runs regardless of `enable_i`.
- Two-state FSM:
  - STABLE: `sync == data_o`.
  - PENDING: `sync != data_o`.
  - `cnt` is CNT_WIDTH bits and resets to 0.
- Per-cycle rules, evaluated in priority order:
  1. `enable_i == 0`: `cnt <= 0`; `data_o` holds; state goes to STABLE.
  2. `sync == data_o`: `cnt <= 0`; state goes to STABLE. This covers a glitch that ends before acceptance, which restarts the count.
  3. `sync != data_o` and `cnt >= threshold_i`: `data_o <= sync`; `cnt <= 0`; assert the matching edge strobe next cycle; state goes to STABLE.
  4. `sync != data_o` otherwise: `cnt <= cnt + 1`, saturating at all-ones; state goes to PENDING.
- `threshold_i == 0`: a change is accepted on the first mismatching cycle, giving plain synchronized pass-through.
- `threshold_i` is sampled every cycle. Lowering it mid-count below `cnt` causes acceptance on the next mismatching cycle, because the compare is `>=`.
- `rise_o` and `fall_o` are registered. They are high for exactly the one cycle in which `data_o` first shows the new value. They are never both high.
- Reset:
  - `data_o = RESET_VAL`, `rise_o = 0`, `fall_o = 0`, `cnt = 0`.
  - Asserting reset mid-PENDING discards the count and produces no strobe.
  - Release of reset never produces a strobe.

## Timing
- Latency from a pad transition to the `data_o` change is `SYNC_STAGES + threshold_i + 1` rising edges of `clk_i`, with ±1 cycle of synchronizer uncertainty.
- Minimum accepted pulse width is `threshold_i + 1` consecutive cycles of the same `sync` value. Shorter pulses produce no change on `data_o` and no strobe.
- Strobes coincide with the `data_o` update; there is no additional latency.
- No combinational path from any input to any output.

## Configuration
- `PAD_DEBOUNCE_EDGE_EN`:
  - Defined: the `rise_o`/`fall_o` strobe flops are instantiated as described above.
  - Undefined: `rise_o` and `fall_o` are tied to constant 0, and no strobe logic is generated.
  - Both builds have identical `data_o` behaviour and identical port lists.

## Test plan
- Reset: hold `rst_ni = 0` with `pad_i = 1` and `RESET_VAL = 0` -> `data_o = 0`, `rise_o = fall_o = 0`. After release with `pad_i = 1` and `threshold_i = 3`, `data_o` rises 2+3+1 = 6 cycles later, with `rise_o` high for exactly that cycle (EDGE_EN build).
- Glitch reject: `threshold_i = 4`, `data_o = 0`, drive `pad_i = 1` for 4 cycles then 0 -> `data_o` stays 0 and no strobe occurs. Then drive `pad_i = 1` for 5 cycles -> `data_o = 1` and one `rise_o` pulse.
- Pass-through: `threshold_i = 0`, toggle `pad_i` every 3 cycles -> `data_o` follows with a fixed 3-cycle delay (SYNC_STAGES = 2). There is one strobe per toggle, alternating `rise_o`/`fall_o`.
- Enable gating: start a pending change, then drop `enable_i` for 10 cycles -> `data_o` holds and `cnt` clears. Raise `enable_i` -> acceptance after a full `threshold_i + 1` cycles.
- Threshold change mid-count: `threshold_i = 200`, mismatch for 50 cycles, then set `threshold_i = 10` -> accepted on the next cycle.
- Reset mid-PENDING and saturation: assert `rst_ni` during a pending change -> no strobe and `data_o = RESET_VAL`. With `threshold_i = 255` (CNT_WIDTH = 8) and a steady mismatch -> accepted after 256 mismatching cycles; `cnt` does not wrap.
